// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO on an inferred synchronous-read RAM.
// RDATA is the RAM read register; COUNT includes the word held there.
module ram_fifo #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic                  CLEAR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [WIDTH-1:0]      WDATA,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [WIDTH-1:0]      RDATA,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY
);

  localparam int               DEPTH   = 1 << ADDR_WIDTH;
  localparam int               CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]    AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]    AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0]      mem_q [0:DEPTH-1];
  logic [WIDTH-1:0]      rdata_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wready_q, wready_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  push_s, pop_s, rd_issue_s;

  // Handshake decode and next-state for pointers, occupancy and flags
  always_comb begin
    push_s      = WVALID && wready_q;
    pop_s       = rvalid_q && RREADY;
    // ram_count_q only covers words written on earlier edges, so a word
    // being written now is never read on the same edge.
    rd_issue_s  = (ram_count_q != {CW{1'b0}}) && (!rvalid_q || pop_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    rvalid_d    = rvalid_q;
    if (CLEAR) begin
      wr_ptr_d    = {ADDR_WIDTH{1'b0}};
      rd_ptr_d    = {ADDR_WIDTH{1'b0}};
      ram_count_d = {CW{1'b0}};
      rvalid_d    = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_issue_s) begin
        rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        rvalid_d = 1'b1;
      end else if (pop_s) begin
        rvalid_d = 1'b0;
      end else begin
        rvalid_d = rvalid_q;
      end
      ram_count_d = ram_count_q + CW'(push_s) - CW'(rd_issue_s);
    end
    wready_d = (ram_count_d != DEPTH_C);
    count_d  = ram_count_d + CW'(rvalid_d);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      ram_count_q <= {CW{1'b0}};
      count_q     <= {CW{1'b0}};
      rvalid_q    <= 1'b0;
      wready_q    <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      count_q     <= count_d;
      rvalid_q    <= rvalid_d;
      wready_q    <= wready_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
    end
  end

  // RAM array and its read register; left unreset so it maps to block RAM
  always_ff @(posedge CLK) begin
    if (push_s && !CLEAR) begin
      mem_q[wr_ptr_q] <= WDATA;
    end
    if (rd_issue_s && !CLEAR) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign WREADY       = wready_q;
  assign RVALID       = rvalid_q;
  assign RDATA        = rdata_q;
  assign COUNT        = count_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;

endmodule
